// File: rtl/cluster_input_frame_loader_if.sv
// Stream-in / frame-out bundle between the word feeder, the frame loader and the evaluator consumer.
interface cluster_input_frame_loader_if #(
    parameter int unsigned FRAME_W = 1894,
    parameter int unsigned WORD_W  = 32
);
    logic               s_valid;
    logic               s_ready;
    logic [WORD_W-1:0]  s_data;
    logic               s_last;
    logic [FRAME_W-1:0] frame_o;
    logic               frame_valid;
    logic               frame_ready;

    modport master (
        output s_valid, s_data, s_last, frame_ready,
        input  s_ready, frame_o, frame_valid
    );

    modport slave (
        input  s_valid, s_data, s_last, frame_ready,
        output s_ready, frame_o, frame_valid
    );
endinterface

// File: rtl/cluster_input_frame_loader.sv
// Assembles a wide cluster input frame from a word stream into a shadow buffer, commits it to a
// stable front register, lets it settle, then offers it to the evaluators via frame_valid/frame_ready.
module cluster_input_frame_loader #(
    parameter int unsigned FRAME_W    = 1894,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    cluster_input_frame_loader_if.slave   bus,
    output logic                          err_short,
    output logic                          err_long,
    output logic [5:0]                    beat_cnt
);
    localparam int unsigned BEATS  = (FRAME_W + WORD_W - 1) / WORD_W;
    localparam int unsigned LAST_W = FRAME_W - (BEATS - 1) * WORD_W;
    localparam int unsigned BEAT_W = 6;
    localparam int unsigned SET_W  = 4;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [SET_W-1:0]  SETTLE_END = SET_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {FILL, FULL, DRAIN} fill_t;
    typedef enum logic [1:0] {EMPTY, SETTLE, PRESENT} front_t;

    fill_t               fill_q, fill_d;
    front_t              front_q, front_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [FRAME_W-1:0]  shadow_q, shadow_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                frame_valid_q, frame_valid_d;
    logic                s_ready_q, s_ready_d;
    logic                err_short_q, err_short_d;
    logic                err_long_q, err_long_d;
    logic                accept_c, last_beat_c, allow_c, commit_c;

    assign accept_c    = bus.s_valid & s_ready_q;
    assign last_beat_c = (beat_q == LAST_BEAT);
    // Front register may take a new frame when empty or when the consumer releases it this cycle.
    assign allow_c     = (front_q == EMPTY) || ((front_q == PRESENT) && bus.frame_ready);

    always_comb begin
        fill_d        = fill_q;
        front_d       = front_q;
        settle_d      = settle_q;
        beat_d        = beat_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        err_short_d   = 1'b0;
        err_long_d    = 1'b0;
        commit_c      = 1'b0;

        if ((fill_q == FILL) && accept_c) begin
            for (int k = 0; k < int'(BEATS) - 1; k++) begin
                if (beat_q == BEAT_W'(k)) begin
                    shadow_d[k*WORD_W +: WORD_W] = bus.s_data;
                end
            end
            if (last_beat_c) begin
                shadow_d[(BEATS-1)*WORD_W +: LAST_W] = bus.s_data[LAST_W-1:0];
            end
        end

        case (fill_q)
            FILL: begin
                if (accept_c) begin
                    if (!last_beat_c) begin
                        if (bus.s_last) begin
                            err_short_d = 1'b1;
                            beat_d      = '0;
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end else begin
                        beat_d = '0;
                        if (!bus.s_last) begin
                            err_long_d = 1'b1;
                            fill_d     = DRAIN;
                        end else if (allow_c) begin
                            commit_c = 1'b1;
                        end else begin
                            fill_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (allow_c) begin
                    commit_c = 1'b1;
                    fill_d   = FILL;
                end
            end
            DRAIN: begin
                if (accept_c && bus.s_last) begin
                    fill_d = FILL;
                end
            end
            default: fill_d = FILL;
        endcase

        // A commit always restarts the settle window, whatever the front state was.
        if (commit_c) begin
            frame_d  = shadow_d;
            settle_d = '0;
            front_d  = (SETTLE_CYC == 0) ? PRESENT : SETTLE;
        end else begin
            case (front_q)
                SETTLE: begin
                    if (settle_q == SETTLE_END) begin
                        front_d = PRESENT;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                PRESENT: begin
                    if (bus.frame_ready) begin
                        front_d = EMPTY;
                    end
                end
                default: ;
            endcase
        end

        s_ready_d     = (fill_d != FULL);
        frame_valid_d = (front_d == PRESENT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q        <= FILL;
            front_q       <= EMPTY;
            settle_q      <= '0;
            beat_q        <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            s_ready_q     <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
        end else begin
            fill_q        <= fill_d;
            front_q       <= front_d;
            settle_q      <= settle_d;
            beat_q        <= beat_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            s_ready_q     <= s_ready_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
        end
    end

    // Shadow contents are only meaningful once a full frame has landed, so no reset is needed.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.frame_o     = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign err_short       = err_short_q;
    assign err_long        = err_long_q;
    assign beat_cnt        = beat_q;
endmodule

// File: tb/tb_cluster_input_frame_loader.sv
// Directed bench for cluster_input_frame_loader: settle-2 instance for most scenarios,
// settle-0 instance with frame_ready tied high for the continuous-stream case.
module tb_cluster_input_frame_loader;
    localparam int unsigned FRAME_W = 1894;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BEATS   = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    cluster_input_frame_loader_if #(.FRAME_W(FRAME_W), .WORD_W(WORD_W)) ifa ();
    cluster_input_frame_loader_if #(.FRAME_W(FRAME_W), .WORD_W(WORD_W)) ifb ();

    logic       err_short_a, err_long_a, err_short_b, err_long_b;
    logic [5:0] beat_cnt_a, beat_cnt_b;

    cluster_input_frame_loader #(.FRAME_W(FRAME_W), .WORD_W(WORD_W), .SETTLE_CYC(2)) u_dut (
        .clk(clk), .rst(rst), .bus(ifa.slave),
        .err_short(err_short_a), .err_long(err_long_a), .beat_cnt(beat_cnt_a)
    );

    cluster_input_frame_loader #(.FRAME_W(FRAME_W), .WORD_W(WORD_W), .SETTLE_CYC(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(ifb.slave),
        .err_short(err_short_b), .err_long(err_long_b), .beat_cnt(beat_cnt_b)
    );

    function automatic logic [FRAME_W-1:0] mk_frame(input logic [31:0] base, input logic [31:0] lastw);
        logic [BEATS*WORD_W-1:0] b;
        for (int k = 0; k < int'(BEATS) - 1; k++) b[k*WORD_W +: WORD_W] = base | 32'(k);
        b[(BEATS-1)*WORD_W +: WORD_W] = lastw;
        return b[FRAME_W-1:0];
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l);
        int n = 0;
        ifa.s_valid = 1'b1;
        ifa.s_data  = d;
        ifa.s_last  = l;
        forever begin
            @(negedge clk);
            if (ifa.s_ready) break;
            n++;
            if (n > 200) begin
                vectors++; miscompares++;
                $display("FAIL send_timeout: s_ready=%b, required 1 within 200 cycles", ifa.s_ready);
                break;
            end
        end
        @(posedge clk); #1;
        ifa.s_valid = 1'b0;
        ifa.s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input logic [31:0] lastw);
        for (int k = 0; k < int'(BEATS) - 1; k++) send_word(base | 32'(k), 1'b0);
        send_word(lastw, 1'b1);
    endtask

    task automatic pulse_ready();
        ifa.frame_ready = 1'b1;
        @(posedge clk); #1;
        ifa.frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) send_word(32'h1111_0000 | 32'(k), 1'b0);
        vectors++;
        if (beat_cnt_a !== 6'd5) begin miscompares++; $display("FAIL t1_beat_pre: got %0d want 5", beat_cnt_a); end
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({ifa.s_ready, ifa.frame_valid, err_short_a, err_long_a} !== 4'b0000 || beat_cnt_a !== 6'd0) begin
            miscompares++;
            $display("FAIL t1_rst_outs: got rdy=%b fv=%b es=%b el=%b bc=%0d want all 0",
                     ifa.s_ready, ifa.frame_valid, err_short_a, err_long_a, beat_cnt_a);
        end
        vectors++;
        if (ifa.frame_o !== '0) begin miscompares++; $display("FAIL t1_rst_frame: got low %h want 0", ifa.frame_o[31:0]); end
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (ifa.s_ready !== 1'b0) begin miscompares++; $display("FAIL t1_rdy_in_rst: got %b want 0", ifa.s_ready); end
        @(posedge clk); #1;
        vectors++;
        if (ifa.s_ready !== 1'b1 || ifb.s_ready !== 1'b1) begin
            miscompares++; $display("FAIL t1_rdy_after: got %b/%b want 1/1", ifa.s_ready, ifb.s_ready);
        end
    endtask

    logic [FRAME_W-1:0] exp_f2, exp_f3, exp_f4, exp_fa, exp_fb;

    task automatic test_frame();
        exp_f2 = mk_frame(32'hA5A5_0000, 32'hFFFF_FFC5);
        send_frame(32'hA5A5_0000, 32'hFFFF_FFC5);
        vectors++;
        if (ifa.frame_o !== exp_f2) begin
            miscompares++; $display("FAIL t2_frame: got low %h want %h", ifa.frame_o[31:0], exp_f2[31:0]);
        end
        vectors++;
        if (ifa.frame_o[1893:1888] !== 6'h05) begin
            miscompares++; $display("FAIL t2_top_bits: got %h want 05", ifa.frame_o[1893:1888]);
        end
        vectors++;
        if (ifa.frame_valid !== 1'b0 || beat_cnt_a !== 6'd0) begin
            miscompares++; $display("FAIL t2_e0: got fv=%b bc=%0d want 0/0", ifa.frame_valid, beat_cnt_a);
        end
        @(posedge clk); #1;
        vectors++;
        if (ifa.frame_valid !== 1'b0) begin miscompares++; $display("FAIL t2_fv_e1: got %b want 0", ifa.frame_valid); end
        @(posedge clk); #1;
        vectors++;
        if (ifa.frame_valid !== 1'b1) begin miscompares++; $display("FAIL t2_fv_e2: got %b want 1", ifa.frame_valid); end
    endtask

    task automatic test_short();
        for (int k = 0; k < 10; k++) send_word(32'h2222_0000 | 32'(k), 1'b0);
        send_word(32'h2222_000A, 1'b1);
        vectors++;
        if (err_short_a !== 1'b1 || beat_cnt_a !== 6'd0) begin
            miscompares++; $display("FAIL t3_err_short: got es=%b bc=%0d want 1/0", err_short_a, beat_cnt_a);
        end
        @(posedge clk); #1;
        vectors++;
        if (err_short_a !== 1'b0) begin miscompares++; $display("FAIL t3_pulse_len: got %b want 0", err_short_a); end
        vectors++;
        if (ifa.frame_o !== exp_f2 || ifa.frame_valid !== 1'b1) begin
            miscompares++; $display("FAIL t3_front_kept: got low %h fv=%b want %h 1", ifa.frame_o[31:0], ifa.frame_valid, exp_f2[31:0]);
        end
        pulse_ready();
        vectors++;
        if (ifa.frame_valid !== 1'b0) begin miscompares++; $display("FAIL t3_release: got fv=%b want 0", ifa.frame_valid); end
        exp_f3 = mk_frame(32'h1234_0000, 32'h0000_00EA);
        send_frame(32'h1234_0000, 32'h0000_00EA);
        vectors++;
        if (ifa.frame_o !== exp_f3 || ifa.frame_o[1893:1888] !== 6'h2A) begin
            miscompares++; $display("FAIL t3_next_frame: got low %h top %h want %h 2a", ifa.frame_o[31:0], ifa.frame_o[1893:1888], exp_f3[31:0]);
        end
        repeat (2) @(posedge clk); #1;
        vectors++;
        if (ifa.frame_valid !== 1'b1) begin miscompares++; $display("FAIL t3_fv: got %b want 1", ifa.frame_valid); end
    endtask

    task automatic test_long();
        for (int k = 0; k < 59; k++) send_word(32'h5A5A_0000 | 32'(k), 1'b0);
        send_word(32'h0000_003F, 1'b0);
        vectors++;
        if (err_long_a !== 1'b1 || beat_cnt_a !== 6'd0) begin
            miscompares++; $display("FAIL t4_err_long: got el=%b bc=%0d want 1/0", err_long_a, beat_cnt_a);
        end
        send_word(32'hDEAD_0001, 1'b0);
        vectors++;
        if (err_long_a !== 1'b0 || err_short_a !== 1'b0) begin
            miscompares++; $display("FAIL t4_pulse_len: got el=%b es=%b want 0/0", err_long_a, err_short_a);
        end
        send_word(32'hDEAD_0002, 1'b0);
        send_word(32'hDEAD_0003, 1'b1);
        vectors++;
        if (ifa.frame_o !== exp_f3 || ifa.frame_valid !== 1'b1 || beat_cnt_a !== 6'd0) begin
            miscompares++; $display("FAIL t4_drain: got low %h fv=%b bc=%0d want %h 1 0", ifa.frame_o[31:0], ifa.frame_valid, beat_cnt_a, exp_f3[31:0]);
        end
        pulse_ready();
        exp_f4 = mk_frame(32'h0F0F_0000, 32'h1234_5678);
        send_word(32'h0F0F_0000, 1'b0);
        vectors++;
        if (beat_cnt_a !== 6'd1) begin miscompares++; $display("FAIL t4_restart: got bc=%0d want 1", beat_cnt_a); end
        for (int k = 1; k < 59; k++) send_word(32'h0F0F_0000 | 32'(k), 1'b0);
        send_word(32'h1234_5678, 1'b1);
        vectors++;
        if (ifa.frame_o !== exp_f4 || ifa.frame_o[1893:1888] !== 6'h38) begin
            miscompares++; $display("FAIL t4_next_frame: got low %h top %h want %h 38", ifa.frame_o[31:0], ifa.frame_o[1893:1888], exp_f4[31:0]);
        end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        pulse_ready();
        exp_fa = mk_frame(32'hC0DE_0000, 32'h0000_0001);
        exp_fb = mk_frame(32'h7777_0000, 32'h0000_0030);
        send_frame(32'hC0DE_0000, 32'h0000_0001);
        send_frame(32'h7777_0000, 32'h0000_0030);
        vectors++;
        if (ifa.s_ready !== 1'b0 || ifa.frame_valid !== 1'b1 || ifa.frame_o !== exp_fa) begin
            miscompares++; $display("FAIL t5_full: got rdy=%b fv=%b low %h want 0 1 %h", ifa.s_ready, ifa.frame_valid, ifa.frame_o[31:0], exp_fa[31:0]);
        end
        repeat (3) @(posedge clk); #1;
        vectors++;
        if (ifa.s_ready !== 1'b0 || ifa.frame_o !== exp_fa) begin
            miscompares++; $display("FAIL t5_hold: got rdy=%b low %h want 0 %h", ifa.s_ready, ifa.frame_o[31:0], exp_fa[31:0]);
        end
        pulse_ready();
        vectors++;
        if (ifa.frame_o !== exp_fb || ifa.frame_valid !== 1'b0 || ifa.s_ready !== 1'b1) begin
            miscompares++; $display("FAIL t5_commit: got low %h fv=%b rdy=%b want %h 0 1", ifa.frame_o[31:0], ifa.frame_valid, ifa.s_ready, exp_fb[31:0]);
        end
        @(posedge clk); #1;
        vectors++;
        if (ifa.frame_valid !== 1'b0) begin miscompares++; $display("FAIL t5_fv_e1: got %b want 0", ifa.frame_valid); end
        @(posedge clk); #1;
        vectors++;
        if (ifa.frame_valid !== 1'b1) begin miscompares++; $display("FAIL t5_fv_e2: got %b want 1", ifa.frame_valid); end
    endtask

    task automatic test_stream_settle0();
        int stalls  = 0;
        int commits = 0;
        logic [FRAME_W-1:0] exp_last;
        exp_last = mk_frame(32'h3302_0000, 32'hABCD_EF12);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < int'(BEATS); k++) begin
                ifb.s_valid = 1'b1;
                ifb.s_last  = (k == int'(BEATS) - 1);
                ifb.s_data  = (k == int'(BEATS) - 1) ? (32'hABCD_EF00 | 32'(f + 16))
                                                      : (32'h3300_0000 | (32'(f) << 16) | 32'(k));
                forever begin
                    @(negedge clk);
                    if (ifb.frame_valid) commits++;
                    if (ifb.s_ready) break;
                    stalls++;
                    if (stalls > 50) break;
                end
                @(posedge clk); #1;
            end
        end
        ifb.s_valid = 1'b0;
        ifb.s_last  = 1'b0;
        @(negedge clk);
        if (ifb.frame_valid) commits++;
        vectors++;
        if (stalls !== 0) begin miscompares++; $display("FAIL t6_stalls: got %0d want 0", stalls); end
        vectors++;
        if (commits !== 3) begin miscompares++; $display("FAIL t6_commits: got %0d want 3", commits); end
        vectors++;
        if (ifb.frame_o !== exp_last || ifb.frame_o[1893:1888] !== 6'h12) begin
            miscompares++; $display("FAIL t6_frame: got low %h top %h want %h 12", ifb.frame_o[31:0], ifb.frame_o[1893:1888], exp_last[31:0]);
        end
        @(posedge clk); #1;
        vectors++;
        if (ifb.frame_valid !== 1'b0 || err_short_b !== 1'b0 || err_long_b !== 1'b0 || beat_cnt_b !== 6'd0) begin
            miscompares++; $display("FAIL t6_idle: got fv=%b es=%b el=%b bc=%0d want 0 0 0 0", ifb.frame_valid, err_short_b, err_long_b, beat_cnt_b);
        end
    endtask

    initial begin
        ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_last = 1'b0; ifa.frame_ready = 1'b0;
        ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_last = 1'b0; ifb.frame_ready = 1'b1;
        test_reset();
        test_frame();
        test_short();
        test_long();
        test_back_to_back();
        test_stream_settle0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
